guvm_wb_stim_slave: RTL
=======================

# guvm_wb_stim_slave

Parametrised Wishbone classic slave for the GUVM core bench. It sits between the DUT's Wishbone master port and the UVM driver/monitor. Reads return buffered instruction words in an address-selected lane, with the NOP fill pattern in all other lanes. Writes are captured into a buffered monitor stream. Data width, buffer depth and wait states are configurable, so one block serves 32/64/128-bit cores.

## Interface
Parameters:
- DATA_W, 128, Wishbone data width; 32, 64 or 128.
- ADR_W, 32, Wishbone address width.
- INST_W, 32, instruction word width; DATA_W is a multiple of it.
- DEPTH, 8, entries in each of the instruction FIFO and the capture FIFO; power of two, ≥2.
- WAIT, 0, wait states inserted before ack; 0..15.
- FILL, 32'hF0081003, NOP word placed in unused read lanes.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone cycle, strobe and write enable from the DUT.
- i_wb_adr  in  ADR_W  byte address.
- i_wb_sel  in  DATA_W/8  byte selects.
- i_wb_dat  in  DATA_W  DUT write data.
- o_wb_dat  out  DATA_W  read data to the DUT.
- o_wb_ack, o_wb_err  out  1  cycle termination.
- i_inst_valid  in  1 / o_inst_ready  out  1 / i_inst  in  INST_W  driver push interface.
- o_cap_valid  out  1 / i_cap_ready  in  1  monitor pop handshake.
- o_cap_adr  out  ADR_W / o_cap_sel  out  DATA_W/8 / o_cap_dat  out  DATA_W  captured write.
- o_inst_count  out  $clog2(DEPTH)+1  instruction FIFO occupancy.
- o_overflow  out  1  sticky; set when a capture is dropped.

## Operation
- FSM states IDLE, WAIT, ACK.
- IDLE, when i_wb_cyc & i_wb_stb is sampled:
  - go to ACK if WAIT==0;
  - otherwise go to WAIT and load the counter with WAIT-1.
- WAIT decrements the counter each cycle and goes to ACK at 0.
- WAIT returns to IDLE with no ack, pop or push if i_wb_cyc or i_wb_stb is low.
- ACK asserts o_wb_ack (or o_wb_err) for exactly one cycle, then returns to IDLE.
- Read in ACK:
  - the lane index is i_wb_adr[$clog2(DATA_W/8)-1:$clog2(INST_W/8)];
  - the instruction FIFO head goes in that lane and FILL in all other lanes;
  - the head is popped.
- Read with the instruction FIFO empty: all lanes carry FILL, no pop, ack is still given.
- Write in ACK: {adr, sel, dat} is pushed into the capture FIFO.
- Write with the capture FIFO full: ack is still given, the data is dropped, and o_overflow is set.
- Instruction FIFO:
  - o_inst_ready = !full;
  - a push occurs when valid & ready;
  - a push and an ACK pop in the same cycle are both honoured and the count is unchanged;
  - when full, no push is accepted even if a pop occurs that cycle.
- Capture FIFO:
  - it is show-ahead and o_cap_valid = !empty;
  - a pop occurs when o_cap_valid & i_cap_ready;
  - a simultaneous push and pop are both honoured.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; the count is tracked separately.
- Reset values: FSM IDLE; o_wb_ack=0, o_wb_err=0, o_wb_dat=0; both FIFOs empty; o_inst_ready=1; o_cap_valid=0; o_inst_count=0; o_overflow=0.
- Reset during WAIT or ACK aborts the transaction, with no pop and no push.

## Timing
- Ack latency: request sampled in cycle n gives ack in cycle n+WAIT+1.
- o_wb_dat is valid only in the ack cycle and is 0 otherwise.
- Back-to-back: with stb held high, acks are spaced WAIT+2 cycles apart (one IDLE cycle between them).
- A word pushed in cycle n is available to a read acked in cycle n+1 or later.
- A capture pushed in cycle n gives o_cap_valid in cycle n+1.
- o_inst_count and o_overflow are registered and update in the cycle after the event.

## Configuration
- GUVM_WB_ERR_INJECT_EN defined:
  - adds ports i_inj_arm (in, 1) and i_inj_adr (in, ADR_W);
  - i_inj_arm pulsed high latches i_inj_adr and sets an armed flag;
  - the next transaction whose i_wb_adr matches terminates with o_wb_err=1 instead of ack, with no pop and no push;
  - the flag clears after that one error;
  - reset clears the flag.
- GUVM_WB_ERR_INJECT_EN undefined: the inject ports are absent and o_wb_err is constant 0.

## Test plan
- Read lane placement. DATA_W=128, WAIT=0, push 32'hE3A01005, read adr 0x8 -> ack one cycle later, o_wb_dat = {FILL, 32'hE3A01005, FILL, FILL}, o_inst_count 1→0.
- Empty FIFO read. Read adr 0x0 with no pushes -> o_wb_dat = {4{32'hF0081003}}, ack asserted, count stays 0.
- Wait states. WAIT=3, stb held for two reads -> acks exactly 4 cycles after sampling, spaced 5 cycles apart.
- Capture. Write adr 0x100, sel 16'h000F, dat 0x...DEADBEEF -> o_cap_valid next cycle with matching fields. After DEPTH+1 writes with i_cap_ready=0 -> o_overflow=1, only the first DEPTH writes are retained.
- Abort and reset. WAIT=5, drop stb after 2 cycles -> no ack, count unchanged. Assert i_rst in the ACK cycle -> ack low next cycle, FIFOs empty, o_inst_ready=1.
- Error injection (GUVM_WB_ERR_INJECT_EN). Arm adr 0x40, read 0x40 -> o_wb_err=1, o_wb_ack=0, no pop. A second read of 0x40 -> normal ack.

Source files
------------

// File: rtl/guvm_wb_stim_slave.sv
// Wishbone classic slave: reads drain an instruction FIFO into an address-selected lane, writes fill a capture FIFO.
// Optional error injection is built in when GUVM_WB_ERR_INJECT_EN is defined.
module guvm_wb_stim_slave #(
  parameter int DATA_W = 128,
  parameter int ADR_W  = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 8,
  parameter int WAIT   = 0,
  parameter logic [INST_W-1:0] FILL = 32'hF0081003
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  input  logic                      i_wb_we,
  input  logic [ADR_W-1:0]          i_wb_adr,
  input  logic [DATA_W/8-1:0]       i_wb_sel,
  input  logic [DATA_W-1:0]         i_wb_dat,
  output logic [DATA_W-1:0]         o_wb_dat,
  output logic                      o_wb_ack,
  output logic                      o_wb_err,
  input  logic                      i_inst_valid,
  output logic                      o_inst_ready,
  input  logic [INST_W-1:0]         i_inst,
  output logic                      o_cap_valid,
  input  logic                      i_cap_ready,
  output logic [ADR_W-1:0]          o_cap_adr,
  output logic [DATA_W/8-1:0]       o_cap_sel,
  output logic [DATA_W-1:0]         o_cap_dat,
  output logic [$clog2(DEPTH):0]    o_inst_count,
  output logic                      o_overflow
`ifdef GUVM_WB_ERR_INJECT_EN
  ,
  input  logic                      i_inj_arm,
  input  logic [ADR_W-1:0]          i_inj_adr
`endif
);

  localparam int SW    = DATA_W / 8;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int LANES = DATA_W / INST_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CAPW  = ADR_W + SW + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic       req, inj_hit, rd_ack, wr_ack;

  assign req    = i_wb_cyc & i_wb_stb;
  assign rd_ack = ack_q & ~i_wb_we;
  assign wr_ack = ack_q & i_wb_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d = S_ACK;
            ack_d   = ~inj_hit;
            err_d   = inj_hit;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT - 1);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          ack_d   = ~inj_hit;
          err_d   = inj_hit;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;

  // Instruction FIFO: driver pushes, read acks pop the head.
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PW-1:0]     inst_wp_q, inst_wp_d, inst_rp_q, inst_rp_d;
  logic [CW-1:0]     inst_cnt_q, inst_cnt_d;
  logic              inst_full, inst_empty, inst_push, inst_pop;

  assign inst_full  = (inst_cnt_q == CW'(DEPTH));
  assign inst_empty = (inst_cnt_q == '0);
  assign inst_push  = i_inst_valid & ~inst_full;
  assign inst_pop   = rd_ack & ~inst_empty;

  always_comb begin
    inst_wp_d  = inst_wp_q + PW'(inst_push);
    inst_rp_d  = inst_rp_q + PW'(inst_pop);
    inst_cnt_d = inst_cnt_q + CW'(inst_push) - CW'(inst_pop);
  end

  always_ff @(posedge i_clk) begin
    if (inst_push) inst_mem[inst_wp_q] <= i_inst;
  end

  assign o_inst_ready = ~inst_full;
  assign o_inst_count = inst_cnt_q;

  // Read data: head word in the addressed lane, FILL elsewhere; zero outside the read ack.
  logic [LW-1:0]     lane_idx;
  logic [DATA_W-1:0] rd_data;

  if (LANES > 1) begin : g_lane_sel
    assign lane_idx = i_wb_adr[$clog2(DATA_W/8)-1 -: LW];
  end else begin : g_lane_one
    assign lane_idx = '0;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign rd_data[gi*INST_W +: INST_W] =
      (!inst_empty && lane_idx == LW'(gi)) ? inst_mem[inst_rp_q] : FILL;
  end

  assign o_wb_dat = rd_ack ? rd_data : '0;

  // Capture FIFO: show-ahead, write acks push, full writes are dropped and flagged.
  logic [CAPW-1:0] cap_mem [DEPTH];
  logic [PW-1:0]   cap_wp_q, cap_wp_d, cap_rp_q, cap_rp_d;
  logic [CW-1:0]   cap_cnt_q, cap_cnt_d;
  logic            cap_full, cap_push, cap_pop, overflow_q, overflow_d;

  assign cap_full    = (cap_cnt_q == CW'(DEPTH));
  assign o_cap_valid = (cap_cnt_q != '0);
  assign cap_push    = wr_ack & ~cap_full;
  assign cap_pop     = o_cap_valid & i_cap_ready;

  always_comb begin
    cap_wp_d   = cap_wp_q + PW'(cap_push);
    cap_rp_d   = cap_rp_q + PW'(cap_pop);
    cap_cnt_d  = cap_cnt_q + CW'(cap_push) - CW'(cap_pop);
    overflow_d = overflow_q | (wr_ack & cap_full);
  end

  always_ff @(posedge i_clk) begin
    if (cap_push) cap_mem[cap_wp_q] <= {i_wb_adr, i_wb_sel, i_wb_dat};
  end

  assign {o_cap_adr, o_cap_sel, o_cap_dat} = cap_mem[cap_rp_q];
  assign o_overflow = overflow_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_wp_q  <= '0;
      inst_rp_q  <= '0;
      inst_cnt_q <= '0;
      cap_wp_q   <= '0;
      cap_rp_q   <= '0;
      cap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      inst_wp_q  <= inst_wp_d;
      inst_rp_q  <= inst_rp_d;
      inst_cnt_q <= inst_cnt_d;
      cap_wp_q   <= cap_wp_d;
      cap_rp_q   <= cap_rp_d;
      cap_cnt_q  <= cap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef GUVM_WB_ERR_INJECT_EN
  logic             armed_q, armed_d;
  logic [ADR_W-1:0] inj_adr_q, inj_adr_d;

  assign inj_hit = armed_q & (i_wb_adr == inj_adr_q);

  // A fresh arm pulse wins over the clear from the error it may coincide with.
  always_comb begin
    armed_d   = armed_q;
    inj_adr_d = inj_adr_q;
    if (err_q) armed_d = 1'b0;
    if (i_inj_arm) begin
      armed_d   = 1'b1;
      inj_adr_d = i_inj_adr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed_q   <= 1'b0;
      inj_adr_q <= '0;
    end else begin
      armed_q   <= armed_d;
      inj_adr_q <= inj_adr_d;
    end
  end
`else
  assign inj_hit = 1'b0;
`endif

endmodule
